demux_16_to_16x16_collect: RTL
==============================

Name: demux_16_to_16x16_collect

Overview:
Inverse of the 16x16-to-16 lane mux. Accepts 16-bit words over a valid/ready handshake and steers each word into one of 16 registered lanes. When all 16 lanes hold fresh data, it presents the packed 256-bit bus with a valid/ready output handshake. Sits upstream of mux_16x16_to_16 and produces the bus that mux consumes.

Parameters:
WIDTH, 16, bits per lane
LANES, 16, number of lanes (fixed at 16; SEL_W derived)
SEL_W, 4, lane index width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  producer has a word
in_ready  output  1  block accepts a word this cycle
in_data  input  16  word to store
in_addr  input  4  target lane, used when addr_mode=1
addr_mode  input  1  0 = auto-increment pointer, 1 = explicit in_addr
out_valid  output  1  full 256-bit frame available
out_ready  input  1  consumer takes the frame
out  output  256  packed lanes; lane i = out[16*i+15 : 16*i]
wr_ptr  output  4  next lane in auto mode
lane_written  output  16  bit i set once lane i has been written this frame

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: out=0, lane_written=0, wr_ptr=0, state=FILL, out_valid=0. in_ready=0 while rst=1.
- FSM states: FILL, HOLD.
- FILL outputs: in_ready=1, out_valid=0.
- HOLD outputs: in_ready=0, out_valid=1.
- Accept: occurs when in_valid & in_ready at a clk edge.
  - Target lane t = addr_mode ? in_addr : wr_ptr.
  - Lane t <= in_data. lane_written[t] <= 1.
  - wr_ptr <= t+1, wrapping mod 16 (15 -> 0). This applies in both modes.
  - Write latency: 1 cycle; the new lane value is visible on out after the accepting edge.
- Duplicate writes: rewriting an already-written lane overwrites its data and does not advance completion.
- FILL -> HOLD: on the edge where the accept makes lane_written all ones. out_valid rises in the following cycle.
- HOLD -> FILL: on the edge where out_valid & out_ready.
  - lane_written <= 0, wr_ptr <= 0.
  - out keeps its lane contents; stale data is not cleared.
  - in_ready returns to 1 in the next cycle; there is no same-cycle pass-through.
- Back-pressure: out is stable throughout HOLD. in_valid is ignored in HOLD.
- Simultaneous events: in HOLD, in_valid and out_ready may both be high; only the frame release happens.
- rst has priority over every other event and aborts a partial frame. All written lanes return to 0.
- out_ready is don't-care in FILL.

Optional Feature:
COLLECT_READBACK_EN
- Defined: adds input rd_addr[3:0] and output rd_data[15:0]. rd_data = lane rd_addr of out, combinational, valid in any state.
- Undefined: those ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - constants WIDTH=16, LANES=16, SEL_W=4
  - FSM state encoding (FILL=0, HOLD=1)
  - a lane-slice helper returning bits [16*i+15:16*i]
- The readback path instantiates the existing mux_16x16_to_16 (out=rd_data, In=out, S=rd_addr).
- No other sub-module is needed; lane registers and the FSM live in one module.

Test Plan:
- Reset then auto mode, 16 accepts of ffff, eeee, ..., 0000 back-to-back:
  - out = {0000,1111,...,eeee,ffff}.
  - lane_written = ffff.
  - out_valid=1 the cycle after the 16th accept; in_ready=0.
- HOLD with out_ready=0 for 10 cycles while in_valid=1 and in_data=1234:
  - out unchanged, no lane written.
  - Then out_ready=1 for 1 cycle: out_valid=0, wr_ptr=0, lane_written=0, in_ready=1 the next cycle.
- Explicit mode, lanes 15 down to 0 with data 16'h00LL (LL = lane index):
  - Frame completes; lane 7 = 0007.
  - Extra write to lane 3 (data beef) before completion: lane 3 = beef, completion count unaffected.
- Auto mode, 15 writes, then rst=1 for one cycle:
  - out=0, lane_written=0, wr_ptr=0, out_valid=0.
  - 16 further writes complete a frame normally.
- In auto mode, write in_addr=14 in explicit mode, then switch to auto mode:
  - Next auto writes land in lane 15, then lane 0 (wrap).
- COLLECT_READBACK_EN: after the first scenario, rd_addr=7 -> rd_data=8888; rd_addr=0 -> ffff; rd_addr=15 -> 0000.

Source files
------------

// File: rtl/demux_16_to_16x16_collect_pkg.sv
// demux_16_to_16x16_collect_pkg: shared lane constants, FSM encoding and lane-slice helper
package demux_16_to_16x16_collect_pkg;
    localparam int WIDTH = 16;
    localparam int LANES = 16;
    localparam int SEL_W = 4;
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;
    function automatic logic [WIDTH-1:0] lane_slice(input logic [WIDTH*LANES-1:0] bus, input logic [SEL_W-1:0] i);
        return bus[WIDTH*int'(i) +: WIDTH];
    endfunction
endpackage

// File: rtl/demux_16_to_16x16_collect_mux.sv
// mux_16x16_to_16: selects one 16-bit lane out of a packed 256-bit bus
module mux_16x16_to_16
    import demux_16_to_16x16_collect_pkg::*;
(
    input  logic [WIDTH*LANES-1:0] In,
    input  logic [SEL_W-1:0]       S,
    output logic [WIDTH-1:0]       out
);
    assign out = lane_slice(In, S);
endmodule

// File: rtl/demux_16_to_16x16_collect.sv
// demux_16_to_16x16_collect: steers 16-bit words into 16 lanes, releases full 256-bit frames.
// Optional COLLECT_READBACK_EN adds rd_addr/rd_data combinational lane readback.
module demux_16_to_16x16_collect
    import demux_16_to_16x16_collect_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_addr,
    input  logic                   addr_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*LANES-1:0] out,
    output logic [SEL_W-1:0]       wr_ptr,
    output logic [LANES-1:0]       lane_written
`ifdef COLLECT_READBACK_EN
    ,
    input  logic [SEL_W-1:0]       rd_addr,
    output logic [WIDTH-1:0]       rd_data
`endif
);
    state_e                 state_q, state_d;
    logic [WIDTH*LANES-1:0] out_q, out_d;
    logic [LANES-1:0]       lw_q, lw_d;
    logic [SEL_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [SEL_W-1:0]       tgt;
    logic                   accept, rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            out_q    <= '0;
            lw_q     <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            lw_q     <= lw_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_comb begin
        tgt      = addr_mode ? in_addr : wr_ptr_q;
        accept   = in_valid && in_ready;
        rel      = out_valid && out_ready;
        out_d    = out_q;
        lw_d     = rel ? '0 : lw_q;
        wr_ptr_d = accept ? tgt + SEL_W'(1) : rel ? '0 : wr_ptr_q;
        if (accept) begin
            out_d[WIDTH*int'(tgt) +: WIDTH] = in_data;
            lw_d[tgt] = 1'b1;
        end
    end

    // Completion is judged on the post-write mask so the 16th accept moves straight to HOLD.
    always_comb begin
        state_d = (state_q == FILL && accept && &lw_d) ? HOLD :
                  (state_q == HOLD && rel) ? FILL : state_q;
    end

    always_comb begin
        in_ready     = (state_q == FILL) && !rst;
        out_valid    = (state_q == HOLD);
        out          = out_q;
        wr_ptr       = wr_ptr_q;
        lane_written = lw_q;
    end

`ifdef COLLECT_READBACK_EN
    mux_16x16_to_16 u_rd_mux (
        .In  (out_q),
        .S   (rd_addr),
        .out (rd_data)
    );
`endif
endmodule
